// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver running on a system clock.
// The raw pins are synchronised and the clock is glitch-filtered. The block
// deframes 11-bit frames, checks the stop bit (and optionally parity),
// aborts stalled frames after a timeout, and queues good bytes in a
// first-word-fall-through FIFO with a valid/ready handshake.
// Optional feature macro: PS2_RX_PARITY_CHECK_EN (odd-parity checking).
module ps2_rx_fifo #(
   parameter int FILTER_LEN  = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 5000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2c,
   input  logic       ps2d,
   input  logic       ready,
   output logic       valid,
   output logic [7:0] d_out,
   output logic       busy,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overflow
);

   localparam int FCW = (FILTER_LEN  > 1) ? $clog2(FILTER_LEN)  : 1;
   localparam int TOW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic           ps2c_s1_reg, ps2c_s2_reg;
   logic           ps2d_s1_reg, ps2d_s2_reg;
   logic           fc_reg;
   logic [FCW-1:0] filt_cnt_reg;
   logic           fall_tick;

   state_t         state_reg;
   logic [2:0]     bit_cnt_reg;
   logic [7:0]     shift_reg;
   logic [TOW-1:0] to_cnt_reg;
   logic           frame_err_reg, parity_err_reg;
   logic           parity_ok;
   logic           push_req;

   logic [7:0]     mem [FIFO_DEPTH];
   logic [AW:0]    wr_ptr_reg, rd_ptr_reg;
   logic           fifo_empty, fifo_full;
   logic           pop, push_ok;
   logic           overflow_reg;

   // Two-stage synchronisers plus the ps2c glitch filter; idle bus level is 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ps2c_s1_reg  <= 1'b1;
         ps2c_s2_reg  <= 1'b1;
         ps2d_s1_reg  <= 1'b1;
         ps2d_s2_reg  <= 1'b1;
         fc_reg       <= 1'b1;
         filt_cnt_reg <= '0;
      end else begin
         ps2c_s1_reg <= ps2c;
         ps2c_s2_reg <= ps2c_s1_reg;
         ps2d_s1_reg <= ps2d;
         ps2d_s2_reg <= ps2d_s1_reg;
         if (ps2c_s2_reg != fc_reg) begin
            if (filt_cnt_reg == FCW'(FILTER_LEN - 1)) begin
               fc_reg       <= ps2c_s2_reg;
               filt_cnt_reg <= '0;
            end else begin
               filt_cnt_reg <= filt_cnt_reg + 1'b1;
            end
         end else begin
            filt_cnt_reg <= '0;
         end
      end
   end

   // The tick is high in the cycle whose closing edge flips fc from 1 to 0.
   assign fall_tick = fc_reg && !ps2c_s2_reg &&
                      (filt_cnt_reg == FCW'(FILTER_LEN - 1));

`ifdef PS2_RX_PARITY_CHECK_EN
   logic parity_reg;

   // Latch the received parity bit for the check at the stop bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         parity_reg <= 1'b0;
      else if (fall_tick && state_reg == PARITY)
         parity_reg <= ps2d_s2_reg;
   end

   assign parity_ok = ^{shift_reg, parity_reg};
`else
   assign parity_ok = 1'b1;
`endif

   assign push_req = fall_tick && (state_reg == STOP) && ps2d_s2_reg && parity_ok;

   // Deframing FSM with timeout watchdog and registered error pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         to_cnt_reg     <= '0;
         frame_err_reg  <= 1'b0;
         parity_err_reg <= 1'b0;
      end else begin
         frame_err_reg  <= 1'b0;
         parity_err_reg <= 1'b0;
         if (fall_tick) begin
            to_cnt_reg <= '0;
            case (state_reg)
               IDLE: begin
                  // A high data bit here is a spurious edge, not an error.
                  if (!ps2d_s2_reg) begin
                     state_reg   <= DATA;
                     bit_cnt_reg <= '0;
                  end
               end
               DATA: begin
                  shift_reg   <= {ps2d_s2_reg, shift_reg[7:1]};
                  bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  if (bit_cnt_reg == 3'd7)
                     state_reg <= PARITY;
               end
               PARITY: state_reg <= STOP;
               STOP: begin
                  state_reg <= IDLE;
                  if (!ps2d_s2_reg)
                     frame_err_reg <= 1'b1;
                  else if (!parity_ok)
                     parity_err_reg <= 1'b1;
               end
               default: state_reg <= IDLE;
            endcase
         end else if (state_reg == IDLE) begin
            to_cnt_reg <= '0;
         end else if (to_cnt_reg == TOW'(TIMEOUT_CYC - 1)) begin
            // Stalled frame: drop the partial byte and wait for a new start.
            state_reg     <= IDLE;
            frame_err_reg <= 1'b1;
            to_cnt_reg    <= '0;
         end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
         end
      end
   end

   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign pop        = !fifo_empty && ready;
   assign push_ok    = push_req && (!fifo_full || pop);

   // FIFO pointers and the overflow pulse; a pop on a full FIFO makes room.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         overflow_reg <= push_req && fifo_full && !pop;
      end
   end

   // Storage array, written only on an accepted push.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_reg[AW-1:0]] <= shift_reg;
   end

   assign valid      = !fifo_empty;
   assign d_out      = fifo_empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];
   assign busy       = (state_reg != IDLE);
   assign frame_err  = frame_err_reg;
   assign parity_err = parity_err_reg;
   assign overflow   = overflow_reg;

endmodule
